// File: rtl/apb_slave_mem.sv
// APB completer backed by a DEPTH x 32-bit register memory, with WAIT_CYCLES
// programmable wait states and PSLVERR on misaligned or out-of-range accesses.
module apb_slave_mem #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic          write_q;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic [31:0]   prdata_q, prdata_d;
  logic [31:0]   mem [DEPTH];

  logic          setup, access, latch_en, complete, mem_we, err;
  logic [31:0]   cur_addr, cur_wdata;
  logic          cur_write;
  logic [29:0]   idx;
  logic [AW-1:0] mem_idx;

  assign setup    = PSEL & ~PENABLE;
  assign access   = PSEL & PENABLE;
  assign latch_en = (state_q == S_IDLE) && setup;

  // With zero wait states the transfer completes on the setup edge itself,
  // so decode must look at the live bus rather than the not-yet-latched copy.
  assign cur_addr  = (state_q == S_IDLE) ? PADDR  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? PWDATA : wdata_q;
  assign cur_write = (state_q == S_IDLE) ? PWRITE : write_q;

  assign idx     = cur_addr[31:2];
  assign mem_idx = idx[AW-1:0];
  assign err     = (cur_addr[1:0] != 2'b00) || ({2'b00, idx} >= 32'(DEPTH));

  // State and datapath register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (latch_en) begin
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
        write_q <= PWRITE;
      end
    end
  end

  // NOTE: the storage is built from resettable flops, not an inferred RAM,
  // because every word must read back as zero after reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    always_ff @(posedge PCLK) begin
      if (PRESET)
        mem[g] <= '0;
      else if (mem_we && (mem_idx == AW'(g)))
        mem[g] <= cur_wdata;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
            state_d  = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!access) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Completion action; outside a completion PREADY/PSLVERR fall back to 0.
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    if (complete) begin
      pready_d  = 1'b1;
      pslverr_d = err;
      if (cur_write)
        mem_we = !err;
      else
        prdata_d = err ? 32'h0 : mem[mem_idx];
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer with a 32-bit word-organised register memory and programmable wait states. It sits directly downstream of the team's APB master: it consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PREADY/PRDATA/PSLVERR. The block gives the master a real target for write/read transfers, wait-state handling and error responses.

## Interface
- DEPTH, 128, number of 32-bit words; legal word index 0..DEPTH-1 (DEPTH ≤ 2^30).
- WAIT_CYCLES, 0, access-phase cycles with PREADY=0 before completion (0..15).
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator from master.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PREADY  out  1  transfer completion, registered.
- PRDATA  out  32  read data, registered.
- PSLVERR  out  1  error response; meaningful only while PREADY=1.

## Operation
- Reset (PRESET=1 at an edge): state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0, all DEPTH words cleared to 0. Reset overrides every other action, including a transfer in WAIT or RESP.
- Address decode on the latched address: idx = addr[31:2]. err = (addr[1:0] != 0) OR (idx >= DEPTH).
- States: IDLE, WAIT, RESP.
- IDLE: PREADY=0. On edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA.
  - If WAIT_CYCLES=0, perform completion action and go RESP.
  - Otherwise, set cnt=WAIT_CYCLES-1 and go WAIT.
  - PSEL=1 with PENABLE=1 in IDLE is ignored; remain IDLE.
- WAIT: PREADY=0.
  - If PSEL=0 or PENABLE=0, abort: go IDLE with no memory change.
  - Else if cnt=0, perform completion action and go RESP.
  - Else cnt decrements.
- Completion action (a single edge):
  - PREADY<=1 and PSLVERR<=err.
  - Write with !err: mem[idx]<=latched data.
  - Read with !err: PRDATA<=mem[idx].
  - Read with err: PRDATA<=0.
  - Write with err: no memory change.
  - A write leaves PRDATA unchanged.
- RESP: PREADY=1 for exactly one cycle. The next edge sets PREADY<=0 and PSLVERR<=0 and goes IDLE unconditionally.
- PRDATA holds its last read value until the next read completion or reset.

## Timing
- Setup phase is cycle T (PSEL=1, PENABLE=0). The access phase starts at T+1.
- PREADY=1 in cycle T+1+WAIT_CYCLES. The transfer completes at the end of that cycle.
- Total transfer length is 2+WAIT_CYCLES cycles.
- Write data becomes visible to reads at the completion edge. A read of the same word issued in the next transfer returns the new value.
- Back-to-back transfers are supported: the cycle after RESP may be the next setup phase, which is sampled in IDLE.
- An aborted transfer (PSEL or PENABLE drops in WAIT) produces no PREADY pulse and no side effect. The block is ready for a new setup one cycle later.
- PRESET asserted mid-WAIT or mid-RESP: the next cycle has PREADY=0 and PSLVERR=0, and nothing is written.
- PSLVERR is never 1 while PREADY=0.

## Test plan
- Reset, then WAIT_CYCLES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> PREADY high in each second cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
- WAIT_CYCLES=2: read 0x0 after reset -> PREADY low for 2 access cycles and high in the 3rd; PRDATA=0x00000000.
- Error responses:
  - Write 0x12345678 to 0x200 (idx 128 ≥ DEPTH) -> PSLVERR=1 with PREADY.
  - Write to 0x13 (misaligned) -> PSLVERR=1.
  - Then read 0x0 -> PSLVERR=0, data 0.
  - Read 0x200 -> PRDATA=0, PSLVERR=1.
- Back-to-back writes to 0x0, 0x4 and 0x1FC, with no idle cycles between transfers, then reads of all three -> each read returns its value; 0x1FC is the last legal word.
- Abort and reset mid-transfer (WAIT_CYCLES=3):
  - Write 0xAA to 0x8, drop PSEL in the 2nd access cycle -> no PREADY pulse; a later read of 0x8 returns 0.
  - Repeat with PRESET pulsed mid-WAIT -> PREADY=0 the next cycle; a read of 0x8 returns 0.
